// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational RISC-V ALU between NUM_REQ requesters.
//
// A valid/ready request is arbitrated. The winner's operands drive the ALU, and the
// result is captured in a one-entry response buffer tagged with the winner's index.
// The buffer can drain and refill in the same cycle, so the block sustains one
// operation per clock.
//
// Compile-time option:
//   ALU_ARB_RR_EN  defined   -> round-robin selection starting at a rotating pointer
//                  undefined -> fixed priority, lowest requester index wins
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   req_valid      per-requester request strobe
//   req_ready      per-requester accept (one-hot or zero)
//   req_src_a/b    per-requester operands, slice i = requester i
//   req_op         per-requester ALU operation code
//   rsp_valid      buffered result belongs to requester i (at most one bit set)
//   rsp_ready      per-requester result consume strobe (only the owner's bit matters)
//   rsp_result     buffered ALU result
//   rsp_id         index of the requester owning rsp_result
//   grant_cnt      total accepted requests, wraps at 16 bits
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ID_W          = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_src_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_src_b,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_result,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [15:0]                      grant_cnt
);

  localparam logic [OPCODE_LENGTH-1:0] OpAnd = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OpOr  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OpAdd = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OpXor = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OpSll = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OpSrl = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OpSub = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OpSra = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OpEq  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OpBge = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OpBne = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OpSlt = OPCODE_LENGTH'(4'b1100);

  localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

  // Response buffer: buf_valid_q is the EMPTY(0)/FULL(1) state.
  logic                  buf_valid_q, buf_valid_d;
  logic [ID_W-1:0]       buf_id_q, buf_id_d;
  logic [DATA_WIDTH-1:0] buf_result_q, buf_result_d;
  logic [15:0]           grant_cnt_q, grant_cnt_d;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0]       ptr_q, ptr_d;
`endif

  logic                     can_accept;
  logic                     win_found;
  logic [ID_W-1:0]          win_id;
  logic                     grant;
  logic [DATA_WIDTH-1:0]    op_a, op_b;
  logic [OPCODE_LENGTH-1:0] op_code;
  logic [4:0]               shamt;
  logic [DATA_WIDTH-1:0]    alu_res;

  // Owner consuming this cycle frees the buffer for a same-cycle refill.
  assign can_accept = !buf_valid_q || rsp_ready[buf_id_q];

  // Winner selection.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
`ifdef ALU_ARB_RR_EN
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % int'(NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
`else
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!win_found && req_valid[k]) begin
        win_found = 1'b1;
        win_id    = ID_W'(k);
      end
    end
`endif
  end

  // rst_n gates the grant so req_ready drops immediately on an asynchronous reset.
  assign grant = rst_n && can_accept && win_found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Shared ALU, fed by the winner's operands.
  assign op_a    = req_src_a[win_id*DATA_WIDTH +: DATA_WIDTH];
  assign op_b    = req_src_b[win_id*DATA_WIDTH +: DATA_WIDTH];
  assign op_code = req_op[win_id*OPCODE_LENGTH +: OPCODE_LENGTH];
  assign shamt   = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (op_code)
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpAdd:   alu_res = op_a + op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpSll:   alu_res = op_a << shamt;
      OpSrl:   alu_res = op_a >> shamt;
      OpSub:   alu_res = op_a - op_b;
      OpSra:   alu_res = DATA_WIDTH'($signed(op_a) >>> shamt);
      OpEq:    alu_res = DATA_WIDTH'(op_a == op_b);
      OpBge:   alu_res = DATA_WIDTH'($signed(op_a) >= $signed(op_b));
      OpBne:   alu_res = DATA_WIDTH'(op_a != op_b);
      OpSlt:   alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
      default: alu_res = '0;
    endcase
  end

  // Next state.
  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_id_d     = buf_id_q;
    buf_result_d = buf_result_q;
    grant_cnt_d  = grant_cnt_q;
`ifdef ALU_ARB_RR_EN
    ptr_d        = ptr_q;
`endif
    if (grant) begin
      buf_valid_d  = 1'b1;
      buf_id_d     = win_id;
      buf_result_d = alu_res;
      grant_cnt_d  = grant_cnt_q + 16'd1;
`ifdef ALU_ARB_RR_EN
      ptr_d        = (win_id == LastId) ? '0 : win_id + ID_W'(1);
`endif
    end else if (buf_valid_q && rsp_ready[buf_id_q]) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q  <= 1'b0;
      buf_id_q     <= '0;
      buf_result_q <= '0;
      grant_cnt_q  <= '0;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= '0;
`endif
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_id_q     <= buf_id_d;
      buf_result_q <= buf_result_d;
      grant_cnt_q  <= grant_cnt_d;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (buf_valid_q) begin
      rsp_valid[buf_id_q] = 1'b1;
    end
  end

  assign rsp_result = buf_result_q;
  assign rsp_id     = buf_id_q;
  assign grant_cnt  = grant_cnt_q;

endmodule
